// File: rtl/seg_bcd_formatter.sv
// seg_bcd_formatter: serial double-dabble binary-to-BCD converter that drives
// an 8-digit seven-segment scanner. One conversion step is done per scan_clk
// cycle, so a 27-bit value takes 27 cycles. The digit registers are updated
// all at once when a conversion completes.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero
// digits. The units digit is always shown. When the macro is undefined, every
// digit enable is tied high.
module seg_bcd_formatter (
  input  logic        scan_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [26:0] value,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  digit_0,
  output logic [3:0]  digit_1,
  output logic [3:0]  digit_2,
  output logic [3:0]  digit_3,
  output logic [3:0]  digit_4,
  output logic [3:0]  digit_5,
  output logic [3:0]  digit_6,
  output logic [3:0]  digit_7,
  output logic        digit_en_0,
  output logic        digit_en_1,
  output logic        digit_en_2,
  output logic        digit_en_3,
  output logic        digit_en_4,
  output logic        digit_en_5,
  output logic        digit_en_6,
  output logic        digit_en_7
);

  typedef enum logic {IDLE, CONV} state_t;

  // Largest value that still fits in eight decimal digits.
  localparam logic [26:0] MAX_DISPLAY = 27'd99_999_999;

  state_t      state_reg;
  logic [26:0] shift_reg;
  logic [31:0] acc_reg;
  logic [4:0]  count_reg;
  logic        ovf_pend_reg;
  logic [31:0] digits_reg;
  logic        done_reg;
  logic        ovf_reg;

  logic [31:0] acc_adj;
  logic [58:0] step_word;
  logic [31:0] acc_next;
  logic [26:0] shift_next;
  logic [31:0] final_digits;

  // Add-3 correction on each BCD nibble before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_adj
      assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                  acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
    end
  endgenerate

  assign step_word  = {acc_adj, shift_reg} << 1;
  assign acc_next   = step_word[58:27];
  assign shift_next = step_word[26:0];

  // Out-of-range values saturate to all nines. This is decided at capture time
  // because the accumulator cannot represent a ninth digit.
  assign final_digits = ovf_pend_reg ? 32'h9999_9999 : acc_next;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [7:0] en_reg;
  logic [7:0] en_next;

  // A digit is lit when it, or any more significant digit, is nonzero.
  assign en_next[7] = |final_digits[31:28];
  generate
    for (gi = 1; gi < 7; gi++) begin : g_blank
      assign en_next[gi] = en_next[gi+1] | (|final_digits[gi*4 +: 4]);
    end
  endgenerate
  assign en_next[0] = 1'b1;
`endif

  // Conversion control: capture on start, step once per cycle in CONV, and
  // publish the digits, enables and overflow together on the final step.
  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      acc_reg      <= '0;
      count_reg    <= '0;
      ovf_pend_reg <= 1'b0;
      digits_reg   <= '0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      en_reg       <= 8'b0000_0001;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            shift_reg    <= value;
            acc_reg      <= '0;
            count_reg    <= 5'd27;
            ovf_pend_reg <= (value > MAX_DISPLAY);
            state_reg    <= CONV;
          end
        end
        CONV: begin
          shift_reg <= shift_next;
          acc_reg   <= acc_next;
          count_reg <= count_reg - 5'd1;
          if (count_reg == 5'd1) begin
            state_reg  <= IDLE;
            digits_reg <= final_digits;
            ovf_reg    <= ovf_pend_reg;
            done_reg   <= 1'b1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            en_reg     <= en_next;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = (state_reg == CONV);
  assign done     = done_reg;
  assign overflow = ovf_reg;

  assign digit_0 = digits_reg[3:0];
  assign digit_1 = digits_reg[7:4];
  assign digit_2 = digits_reg[11:8];
  assign digit_3 = digits_reg[15:12];
  assign digit_4 = digits_reg[19:16];
  assign digit_5 = digits_reg[23:20];
  assign digit_6 = digits_reg[27:24];
  assign digit_7 = digits_reg[31:28];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign digit_en_0 = en_reg[0];
  assign digit_en_1 = en_reg[1];
  assign digit_en_2 = en_reg[2];
  assign digit_en_3 = en_reg[3];
  assign digit_en_4 = en_reg[4];
  assign digit_en_5 = en_reg[5];
  assign digit_en_6 = en_reg[6];
  assign digit_en_7 = en_reg[7];
`else
  assign digit_en_0 = 1'b1;
  assign digit_en_1 = 1'b1;
  assign digit_en_2 = 1'b1;
  assign digit_en_3 = 1'b1;
  assign digit_en_4 = 1'b1;
  assign digit_en_5 = 1'b1;
  assign digit_en_6 = 1'b1;
  assign digit_en_7 = 1'b1;
`endif

endmodule

// File: tb/tb_seg_bcd_formatter.sv
// Randomized testbench for seg_bcd_formatter. It checks the outputs against a
// decimal model that uses division and modulo arithmetic.
module tb_seg_bcd_formatter;

  logic        scan_clk;
  logic        rst_n;
  logic        start;
  logic [26:0] value;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [3:0]  digit_0, digit_1, digit_2, digit_3, digit_4, digit_5, digit_6, digit_7;
  logic        digit_en_0, digit_en_1, digit_en_2, digit_en_3;
  logic        digit_en_4, digit_en_5, digit_en_6, digit_en_7;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_digits;
  logic [7:0]  exp_en;
  logic        exp_ovf;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] RESET_EN = 8'b0000_0001;
`else
  localparam logic [7:0] RESET_EN = 8'hFF;
`endif

  seg_bcd_formatter dut (
    .scan_clk   (scan_clk),
    .rst_n      (rst_n),
    .start      (start),
    .value      (value),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .digit_0    (digit_0),
    .digit_1    (digit_1),
    .digit_2    (digit_2),
    .digit_3    (digit_3),
    .digit_4    (digit_4),
    .digit_5    (digit_5),
    .digit_6    (digit_6),
    .digit_7    (digit_7),
    .digit_en_0 (digit_en_0),
    .digit_en_1 (digit_en_1),
    .digit_en_2 (digit_en_2),
    .digit_en_3 (digit_en_3),
    .digit_en_4 (digit_en_4),
    .digit_en_5 (digit_en_5),
    .digit_en_6 (digit_en_6),
    .digit_en_7 (digit_en_7)
  );

  initial scan_clk = 1'b0;
  always #5 scan_clk = ~scan_clk;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  // Decimal reference. Values above 99,999,999 saturate to all nines.
  function automatic logic [31:0] model_digits(input int unsigned v);
    logic [31:0] d;
    int unsigned p;
    d = '0;
    p = v;
    if (v > 99_999_999) return 32'h9999_9999;
    for (int k = 0; k < 8; k++) begin
      d[k*4 +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return d;
  endfunction

  // Digit k is lit when k is 0 or any digit at position k or above is nonzero.
  function automatic logic [7:0] model_en(input logic [31:0] d);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [7:0] e;
    bit seen;
    e = '0;
    seen = 0;
    for (int k = 7; k >= 0; k--) begin
      if (d[k*4 +: 4] != 0) seen = 1;
      e[k] = seen || (k == 0);
    end
    return e;
`else
    return (d == d) ? 8'hFF : 8'hFF;
`endif
  endfunction

  function automatic logic [31:0] obs_digits();
    return {digit_7, digit_6, digit_5, digit_4, digit_3, digit_2, digit_1, digit_0};
  endfunction

  function automatic logic [7:0] obs_en();
    return {digit_en_7, digit_en_6, digit_en_5, digit_en_4,
            digit_en_3, digit_en_2, digit_en_1, digit_en_0};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},   32'(busy),      32'd0);
    check({tag, "_done"},   32'(done),      32'd0);
    check({tag, "_ovf"},    32'(overflow),  32'd0);
    check({tag, "_digits"}, obs_digits(),   32'd0);
    check({tag, "_en"},     32'(obs_en()),  32'(RESET_EN));
  endtask

  // Run one conversion. While it is in progress, value is scrambled and start
  // is pulsed at random; neither should affect the result.
  task automatic run_conv(input logic [26:0] v, input bit noisy);
    logic [31:0] want_d;
    logic [7:0]  want_e;
    want_d = model_digits(int'(v));
    want_e = model_en(want_d);
    @(negedge scan_clk);
    start = 1'b1;
    value = v;
    @(posedge scan_clk);
    #1;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 1; i <= 26; i++) begin
      @(negedge scan_clk);
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      value = noisy ? 27'($urandom) : v;
      @(posedge scan_clk);
      #1;
      check("busy_conv", 32'(busy), 32'd1);
      check("done_conv", 32'(done), 32'd0);
      check("hold_digits", obs_digits(), exp_digits);
      check("hold_en", 32'(obs_en()), 32'(exp_en));
      check("hold_ovf", 32'(overflow), 32'(exp_ovf));
    end
    // A start on the completion edge must be ignored.
    @(negedge scan_clk);
    start = 1'b1;
    value = 27'($urandom);
    @(posedge scan_clk);
    #1;
    exp_digits = want_d;
    exp_en     = want_e;
    exp_ovf    = (v > 27'd99_999_999);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("digits", obs_digits(), exp_digits);
    check("en", 32'(obs_en()), 32'(exp_en));
    check("ovf", 32'(overflow), 32'(exp_ovf));
    $display("conv value=%0d digits=%08h en=%02h ovf=%0d", v, obs_digits(), obs_en(), overflow);
    @(negedge scan_clk);
    start = 1'b0;
    @(posedge scan_clk);
    #1;
    check("done_single", 32'(done), 32'd0);
    check("start_on_done_ignored", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    value = '0;
    exp_digits = '0;
    exp_en     = RESET_EN;
    exp_ovf    = 1'b0;
    repeat (3) @(posedge scan_clk);
    #1;
    check_reset_state("reset");
    @(negedge scan_clk);
    rst_n = 1'b1;

    // Directed cases: the boundary values and the example values.
    run_conv(27'd0, 1'b0);
    run_conv(27'd12_345_678, 1'b0);
    run_conv(27'd1_000, 1'b0);
    run_conv(27'd134_217_727, 1'b0);
    run_conv(27'd5, 1'b0);
    run_conv(27'd99_999_999, 1'b0);
    run_conv(27'd100_000_000, 1'b0);
    run_conv(27'd42, 1'b1);

    // Assert reset in the middle of a conversion.
    @(negedge scan_clk);
    start = 1'b1;
    value = 27'd99_999_999;
    @(posedge scan_clk);
    @(negedge scan_clk);
    start = 1'b0;
    repeat (12) @(posedge scan_clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_digits = '0;
    exp_en     = RESET_EN;
    exp_ovf    = 1'b0;
    check_reset_state("midconv_reset");
    repeat (20) begin
      @(posedge scan_clk);
      #1;
      check("no_done_in_reset", 32'(done), 32'd0);
    end
    @(negedge scan_clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge scan_clk);
      #1;
      check("no_done_after_reset", 32'(done), 32'd0);
    end
    run_conv(27'd99_999_999, 1'b0);

    // Random values, some restricted to the displayable range.
    for (int t = 0; t < 24; t++) begin
      logic [26:0] rv;
      case (t % 4)
        0:       rv = 27'($urandom);
        1:       rv = 27'($urandom_range(0, 99_999_999));
        2:       rv = 27'($urandom_range(0, 9_999));
        default: rv = 27'($urandom_range(99_999_990, 100_000_010));
      endcase
      run_conv(rv, 1'(t % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
